// File: rtl/hazard_unit_if.sv
// Decode/execute hazard bus: issue-side history feed, decode-stage operand
// query, and the forwarding/stall responses that come back from hazard_unit.
interface hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2
);
    // instruction leaving decode (enters the history)
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  issue_rd_we;
    logic                  issue_is_load;
    // instruction currently in decode (operand query)
    logic                  cur_valid;
    logic [REG_ADDR_W-1:0] cur_rs1;
    logic [REG_ADDR_W-1:0] cur_rs2;
    logic                  flush;
    // responses
    logic                  stall;
    logic [SEL_W-1:0]      fwd_sel_rs1;
    logic [SEL_W-1:0]      fwd_sel_rs2;

    // pipeline side: drives issue/query, receives stall and selects
    modport master (
        output issue_valid, issue_rd, issue_rd_we, issue_is_load,
        output cur_valid, cur_rs1, cur_rs2, flush,
        input  stall, fwd_sel_rs1, fwd_sel_rs2
    );

    // hazard unit side
    modport slave (
        input  issue_valid, issue_rd, issue_rd_we, issue_is_load,
        input  cur_valid, cur_rs1, cur_rs2, flush,
        output stall, fwd_sel_rs1, fwd_sel_rs2
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: multi-depth forwarding control and load-use stall generation.
// Keeps the destination registers of the last FWD_DEPTH issued instructions in
// a shift register (entry 0 = youngest) and, for the instruction in decode,
// picks the youngest live producer of each source operand. A load younger
// than LOAD_LAT entries is not yet forwardable and stalls decode instead.
// Optional build macro HAZARD_STATS_EN adds saturating stall/forward counters.
module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = 2
) (
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]  stall_count,
    output logic [31:0]  fwd_count
`endif
);

    localparam int unsigned DEPTH_U = FWD_DEPTH;
    localparam int unsigned LAT_U   = LOAD_LAT;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;      // already gated by rd_we: 0 means "no write"
        logic                  is_load;
    } entry_t;

    entry_t                  hist [FWD_DEPTH];
    entry_t                  new_entry;
    logic [FWD_DEPTH-1:0]    live;

    // operand 0 = rs1, operand 1 = rs2
    logic [REG_ADDR_W-1:0]   src      [2];
    logic [SEL_W-1:0]        sel      [2];
    logic                    load_hit [2];
    logic                    stall_int;

    assign src[0] = bus.cur_rs1;
    assign src[1] = bus.cur_rs2;

    // Entry to push when decode is not stalled; a non-writing instruction is
    // recorded with rd=0 so it can never match.
    always_comb begin
        new_entry         = '0;
        new_entry.valid   = bus.issue_valid;
        new_entry.rd      = bus.issue_rd & {REG_ADDR_W{bus.issue_rd_we}};
        new_entry.is_load = bus.issue_is_load;
    end

    // An entry can forward only if it is valid and targets a nonzero register.
    always_comb begin
        live = '0;
        for (int unsigned i = 0; i < DEPTH_U; i++) begin
            live[i] = hist[i].valid && (hist[i].rd != '0);
        end
    end

    // Per-operand youngest-match search. Scanning from oldest to youngest lets
    // the youngest hit overwrite older ones, so the load check always refers to
    // the winning producer.
    always_comb begin
        for (int unsigned o = 0; o < 2; o++) begin
            sel[o]      = '0;
            load_hit[o] = 1'b0;
            for (int unsigned i = DEPTH_U; i > 0; i--) begin
                if (live[i-1] && (hist[i-1].rd == src[o])) begin
                    sel[o]      = SEL_W'(i);
                    load_hit[o] = hist[i-1].is_load && ((i - 1) < LAT_U);
                end
            end
            if (!bus.cur_valid || (src[o] == '0)) begin
                sel[o]      = '0;
                load_hit[o] = 1'b0;
            end
        end
    end

    // Load-use stall; a flush in the same cycle always wins.
    always_comb begin
        stall_int = bus.cur_valid && !bus.flush && (load_hit[0] || load_hit[1]);
    end

    assign bus.stall       = stall_int;
    assign bus.fwd_sel_rs1 = sel[0];
    assign bus.fwd_sel_rs2 = sel[1];

    // History shift: flush clears everything, a stall injects a bubble at the
    // young end while older entries keep ageing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_U; i++) begin
                hist[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int unsigned i = 0; i < DEPTH_U; i++) begin
                hist[i] <= '0;
            end
        end else begin
            hist[0] <= stall_int ? entry_t'('0) : new_entry;
            for (int unsigned i = 1; i < DEPTH_U; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic fwd_event;

    // A forwarding event is a decode cycle that actually proceeds and uses at
    // least one bypass path; counted once per cycle regardless of operands.
    always_comb begin
        fwd_event = bus.cur_valid && !stall_int && !bus.flush &&
                    ((sel[0] != '0) || (sel[1] != '0));
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (stall_int && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (fwd_event && (fwd_count != '1)) begin
                fwd_count <= fwd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a vector table on the default configuration
// plus hand sequences for stall length, flush, reset mid-stall, deeper history
// and LOAD_LAT=0. Statistics checks compile only with HAZARD_STATS_EN.
module tb_hazard_unit;

    logic clk;
    logic reset;

    hazard_unit_if #(.REG_ADDR_W(5), .SEL_W(2)) bus_a ();
    hazard_unit_if #(.REG_ADDR_W(5), .SEL_W(2)) bus_b ();
    hazard_unit_if #(.REG_ADDR_W(5), .SEL_W(2)) bus_c ();

`ifdef HAZARD_STATS_EN
    logic [31:0] sc_a, fc_a, sc_b, fc_b, sc_c, fc_c;
`endif

    hazard_unit #(.REG_ADDR_W(5), .FWD_DEPTH(2), .LOAD_LAT(1), .SEL_W(2)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
`ifdef HAZARD_STATS_EN
        , .stall_count(sc_a), .fwd_count(fc_a)
`endif
    );

    hazard_unit #(.REG_ADDR_W(5), .FWD_DEPTH(3), .LOAD_LAT(2), .SEL_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
`ifdef HAZARD_STATS_EN
        , .stall_count(sc_b), .fwd_count(fc_b)
`endif
    );

    hazard_unit #(.REG_ADDR_W(5), .FWD_DEPTH(2), .LOAD_LAT(0), .SEL_W(2)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c)
`ifdef HAZARD_STATS_EN
        , .stall_count(sc_c), .fwd_count(fc_c)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       iv;
        logic [4:0] ird;
        logic       iwe;
        logic       ild;
        logic       cv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       fl;
        logic       st;
        logic [1:0] s1;
        logic [1:0] s2;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t mk(logic iv, logic [4:0] ird, logic iwe, logic ild,
                                logic cv, logic [4:0] rs1, logic [4:0] rs2, logic fl,
                                logic st, logic [1:0] s1, logic [1:0] s2);
        vec_t v;
        v.iv = iv; v.ird = ird; v.iwe = iwe; v.ild = ild;
        v.cv = cv; v.rs1 = rs1; v.rs2 = rs2; v.fl = fl;
        v.st = st; v.s1 = s1; v.s2 = s2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic iv, input logic [4:0] ird, input logic iwe, input logic ild,
                           input logic cv, input logic [4:0] rs1, input logic [4:0] rs2, input logic fl);
        bus_a.issue_valid = iv; bus_a.issue_rd = ird; bus_a.issue_rd_we = iwe; bus_a.issue_is_load = ild;
        bus_a.cur_valid = cv; bus_a.cur_rs1 = rs1; bus_a.cur_rs2 = rs2; bus_a.flush = fl;
    endtask

    task automatic drive_b(input logic iv, input logic [4:0] ird, input logic ild,
                           input logic cv, input logic [4:0] rs1);
        bus_b.issue_valid = iv; bus_b.issue_rd = ird; bus_b.issue_rd_we = 1'b1; bus_b.issue_is_load = ild;
        bus_b.cur_valid = cv; bus_b.cur_rs1 = rs1; bus_b.cur_rs2 = '0; bus_b.flush = 1'b0;
    endtask

    task automatic drive_c(input logic iv, input logic [4:0] ird, input logic ild,
                           input logic cv, input logic [4:0] rs1);
        bus_c.issue_valid = iv; bus_c.issue_rd = ird; bus_c.issue_rd_we = 1'b1; bus_c.issue_is_load = ild;
        bus_c.cur_valid = cv; bus_c.cur_rs1 = rs1; bus_c.cur_rs2 = '0; bus_c.flush = 1'b0;
    endtask

    initial begin : main
        int cnt;

        // iv ird we ld | cv rs1 rs2 fl | stall s1 s2
        vecs[0]  = mk(0,  0, 0, 0,  1, 5, 7, 0,  0, 0, 0);  // empty history after reset
        vecs[1]  = mk(1,  5, 1, 0,  0, 0, 0, 0,  0, 0, 0);  // issue add rd5
        vecs[2]  = mk(0,  0, 0, 0,  1, 5, 0, 0,  0, 1, 0);  // rs1 hits entry0
        vecs[3]  = mk(1,  7, 1, 0,  1, 5, 0, 0,  0, 2, 0);  // rd5 aged to entry1
        vecs[4]  = mk(1,  7, 1, 0,  1, 5, 7, 0,  0, 0, 1);  // rd5 dropped off
        vecs[5]  = mk(0,  0, 0, 0,  1, 0, 7, 0,  0, 0, 1);  // rd7 twice: youngest wins
        vecs[6]  = mk(1,  7, 1, 0,  0, 0, 0, 0,  0, 0, 0);
        vecs[7]  = mk(1,  3, 1, 0,  0, 0, 0, 0,  0, 0, 0);
        vecs[8]  = mk(0,  0, 0, 0,  1, 3, 7, 0,  0, 1, 2);  // rd7 then rd3
        vecs[9]  = mk(0,  0, 0, 0,  0, 3, 3, 0,  0, 0, 0);  // cur_valid=0 gates
        vecs[10] = mk(1,  0, 1, 0,  0, 0, 0, 0,  0, 0, 0);  // rd0 with we
        vecs[11] = mk(1,  4, 0, 0,  0, 0, 0, 0,  0, 0, 0);  // rd4 without we
        vecs[12] = mk(0,  0, 0, 0,  1, 0, 4, 0,  0, 0, 0);
        vecs[13] = mk(1,  9, 1, 1,  0, 0, 0, 0,  0, 0, 0);  // load rd9
        vecs[14] = mk(1, 12, 1, 0,  1, 9, 9, 0,  1, 1, 1);  // load-use; issue ignored
        vecs[15] = mk(0,  0, 0, 0,  1, 9, 12, 0, 0, 2, 0);  // forwards, rd12 never entered
        vecs[16] = mk(1,  9, 1, 1,  0, 0, 0, 0,  0, 0, 0);
        vecs[17] = mk(0,  0, 0, 0,  1, 9, 0, 1,  0, 1, 0);  // flush beats load-use
        vecs[18] = mk(0,  0, 0, 0,  1, 9, 9, 0,  0, 0, 0);  // history cleared
        vecs[19] = mk(1,  6, 1, 0,  0, 0, 0, 0,  0, 0, 0);  // add rd6
        vecs[20] = mk(1,  6, 1, 1,  0, 0, 0, 0,  0, 0, 0);  // load rd6 (younger)
        vecs[21] = mk(0,  0, 0, 0,  1, 0, 6, 0,  1, 0, 1);  // older add does not hide load
        vecs[22] = mk(0,  0, 0, 0,  1, 0, 6, 0,  0, 0, 2);
        vecs[23] = mk(1,  8, 1, 0,  0, 0, 0, 1,  0, 0, 0);  // issue during flush dropped
        vecs[24] = mk(0,  0, 0, 0,  1, 8, 8, 0,  0, 0, 0);
        vecs[25] = mk(1, 10, 1, 1,  0, 0, 0, 0,  0, 0, 0);
        vecs[26] = mk(0,  0, 0, 0,  0, 10, 0, 0, 0, 0, 0);  // no stall without cur_valid
        vecs[27] = mk(0,  0, 0, 0,  1, 10, 0, 0, 0, 2, 0);

        drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        drive_c(0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("reset_stall", {31'd0, bus_a.stall}, 32'd0);
        chk("reset_sel1", {30'd0, bus_a.fwd_sel_rs1}, 32'd0);
        chk("reset_sel2", {30'd0, bus_a.fwd_sel_rs2}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- vector table on dut_a ----------------
        for (int k = 0; k < NVEC; k++) begin
            @(negedge clk);
            drive_a(vecs[k].iv, vecs[k].ird, vecs[k].iwe, vecs[k].ild,
                    vecs[k].cv, vecs[k].rs1, vecs[k].rs2, vecs[k].fl);
            #1;
            chk($sformatf("v%0d_stall", k), {31'd0, bus_a.stall}, {31'd0, vecs[k].st});
            chk($sformatf("v%0d_sel1", k), {30'd0, bus_a.fwd_sel_rs1}, {30'd0, vecs[k].s1});
            chk($sformatf("v%0d_sel2", k), {30'd0, bus_a.fwd_sel_rs2}, {30'd0, vecs[k].s2});
        end

        // ---------------- stall length, LOAD_LAT=1 ----------------
        @(negedge clk); drive_a(1, 9, 1, 1, 0, 0, 0, 0);
        @(negedge clk); drive_a(0, 0, 0, 0, 1, 9, 0, 0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (!bus_a.stall) break;
            cnt++;
            @(negedge clk);
        end
        chk("a_stall_len", cnt, 32'd1);
        chk("a_after_sel1", {30'd0, bus_a.fwd_sel_rs1}, 32'd2);

        // ---------------- reset in the middle of a stall ----------------
        @(negedge clk); drive_a(1, 9, 1, 1, 0, 0, 0, 0);
        @(negedge clk); drive_a(0, 0, 0, 0, 1, 9, 0, 0);
        #1;
        chk("mid_pre_stall", {31'd0, bus_a.stall}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_stall", {31'd0, bus_a.stall}, 32'd0);
        chk("mid_rst_sel1", {30'd0, bus_a.fwd_sel_rs1}, 32'd0);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_stall", {31'd0, bus_a.stall}, 32'd0);
        chk("post_rst_sel1", {30'd0, bus_a.fwd_sel_rs1}, 32'd0);
        drive_a(0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- dut_b: FWD_DEPTH=3, LOAD_LAT=2 ----------------
        @(negedge clk); drive_b(1, 9, 1, 0, 0);
        @(negedge clk); drive_b(0, 0, 0, 1, 9);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (!bus_b.stall) break;
            cnt++;
            @(negedge clk);
        end
        chk("b_stall_len", cnt, 32'd2);
        chk("b_after_sel1", {30'd0, bus_b.fwd_sel_rs1}, 32'd3);
        @(negedge clk); drive_b(1, 11, 0, 0, 0);
        @(negedge clk); drive_b(0, 0, 0, 1, 11);
        #1;
        chk("b_alu_sel1", {30'd0, bus_b.fwd_sel_rs1}, 32'd1);
        chk("b_alu_stall", {31'd0, bus_b.stall}, 32'd0);

        // ---------------- dut_c: LOAD_LAT=0 never stalls ----------------
        @(negedge clk); drive_c(1, 9, 1, 0, 0);
        @(negedge clk); drive_c(0, 0, 0, 1, 9);
        #1;
        chk("c_stall", {31'd0, bus_c.stall}, 32'd0);
        chk("c_sel1", {30'd0, bus_c.fwd_sel_rs1}, 32'd1);
        @(negedge clk); drive_c(0, 0, 0, 0, 0);

`ifdef HAZARD_STATS_EN
        // ---------------- statistics counters ----------------
        @(negedge clk);
        drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("st_reset_sc", sc_a, 32'd0);
        reset = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk); drive_a(1, 9, 1, 1, 0, 0, 0, 0);
            @(negedge clk); drive_a(0, 0, 0, 0, 1, 9, 0, 0);  // stall cycle
            @(negedge clk);                                    // forwarding cycle
            @(negedge clk); drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        end
        #1;
        chk("st_stall_count", sc_a, 32'd3);
        chk("st_fwd_count", fc_a, 32'd3);
        force dut_a.stall_count = 32'hFFFF_FFFD;
        #1;
        release dut_a.stall_count;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk); drive_a(1, 9, 1, 1, 0, 0, 0, 0);
            @(negedge clk); drive_a(0, 0, 0, 0, 1, 9, 0, 0);
            @(negedge clk);
            @(negedge clk); drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        end
        #1;
        chk("st_saturate", sc_a, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
